clk_prescaler: RTL and testbench
================================

Name: clk_prescaler

Overview:
- Programmable clock-enable generator that sits directly upstream of the counter blocks.
- Divides clk by a loadable ratio and emits a one-cycle tick that drives the counter's enable.
- Supports continuous and one-shot modes, a start/stop control handshake, and a running count of ticks emitted.
- Single clock domain.

Parameters:
- DIV_W, 8, width of the divide ratio register and internal prescale counter.
- DEFAULT_DIV, 4, divide ratio loaded at reset; must be 1..2^DIV_W-1.
- TCNT_W, 16, width of the tick_cnt output.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  begin generating ticks; honoured only in IDLE.
- stop  input  1  abort generation; honoured in RUN.
- oneshot  input  1  sampled with start; 1 = emit one tick and then return to IDLE.
- div_load  input  1  load div_in into the ratio register; honoured only in IDLE.
- div_in  input  DIV_W  new divide ratio.
- tick  output  1  registered one-cycle clock-enable pulse.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a one-shot completes.
- load_err  output  1  one-cycle pulse when a load is rejected.
- tick_cnt  output  TCNT_W  number of ticks emitted since the last accepted start.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE, div_reg=DEFAULT_DIV, pc=0, os_reg=0.
  - tick=0, busy=0, done=0, load_err=0, tick_cnt=0.
  - Reset overrides every other input, including mid-RUN.
- All outputs are registered. No combinational path from any input to any output.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 and stop=0: next state RUN; pc<=0; os_reg<=oneshot; tick_cnt<=0; busy=1 from the next edge.
  - start=1 and stop=1 in the same cycle: stop wins; remain in IDLE; no other effect.
  - div_load=1 and div_in!=0: div_reg<=div_in.
  - div_load=1 and div_in==0: div_reg unchanged; load_err=1 for one cycle.
  - div_load and start in the same cycle: the load takes effect first, so the run uses the new ratio.
- RUN:
  - Every edge with stop=0:
    - If pc==div_reg-1: pc<=0, tick<=1, tick_cnt<=tick_cnt+1.
    - Otherwise: pc<=pc+1, tick<=0.
  - Latency: start sampled at edge k gives the first tick high after edge k+div_reg, then one tick every div_reg cycles.
  - div_reg==1 gives tick continuously high from edge k+1.
  - One-shot (os_reg==1): on the terminal edge, tick=1, done=1 and busy=0 together; state returns to IDLE.
  - stop=1: next state IDLE; pc<=0; tick=0 at that edge even if pc was terminal (stop wins); done=0; tick_cnt holds its value.
  - start is ignored; there is no restart.
  - div_load is rejected: div_reg unchanged and load_err=1 for one cycle.
- tick_cnt wraps from 2^TCNT_W-1 to 0 with no flag.
- done and load_err are never high for more than one consecutive cycle per event.

Optional Feature:
- Macro: CLK_PRESCALER_TICK_CNT_EN.
- Defined: tick_cnt counter implemented as described above.
- Undefined: no counter register is built; tick_cnt is tied to 0 at all times. All other behaviour is unchanged.

Test Plan:
- Reset, then hold rst=1 and start=1 for one cycle with DEFAULT_DIV=4 and oneshot=0 -> busy=1 next edge; tick pulses at edges k+4, k+8, k+12; after 3 ticks tick_cnt=3.
- In IDLE, load div_in=1, then start -> tick stays high every cycle from edge k+1; stop -> tick=0 and busy=0 after the next edge; tick_cnt holds.
- Load div_in=3, then start with oneshot=1 -> exactly one tick at edge k+3 with done=1 and busy=0 on that same edge; no further ticks for 20 cycles.
- div_load with div_in=0 in IDLE, and div_load with div_in=7 during RUN -> each gives load_err=1 for one cycle; div_reg is still 4 (verified by the tick spacing).
- Assert stop on the same cycle pc reaches the terminal value, and separately start+stop together in IDLE -> no tick in either case; state is IDLE.
- Drive rst=0 for one edge mid-RUN with div=5 -> all outputs 0 and div_reg=DEFAULT_DIV on the next cycle; a new start produces ticks every 4 cycles.

Source files
------------

// File: rtl/clk_prescaler.sv
// clk_prescaler: loadable clock-enable divider with continuous and one-shot modes.
// Define CLK_PRESCALER_TICK_CNT_EN to build the tick_cnt counter; otherwise tick_cnt reads 0.
module clk_prescaler #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_in,
  output logic              tick,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic [TCNT_W-1:0] tick_cnt
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] r_pc, w_pc_nxt;
  logic             r_os, w_os_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_done, w_done_nxt;
  logic             r_load_err, w_load_err_nxt;
  logic             w_start_ok;
  logic             w_terminal;

  // stop beats start when both arrive together in IDLE
  assign w_start_ok = (r_state == S_IDLE) && start && !stop;
  assign w_terminal = (r_pc == r_div - DIV_ONE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_pc_nxt       = r_pc;
    w_os_nxt       = r_os;
    w_tick_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div_load) begin
          if (div_in != '0) w_div_nxt      = div_in;
          else              w_load_err_nxt = 1'b1;
        end
        if (w_start_ok) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_os_nxt    = oneshot;
        end
      end
      S_RUN: begin
        // the ratio is frozen while running
        w_load_err_nxt = div_load;
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end else if (w_terminal) begin
          w_pc_nxt   = '0;
          w_tick_nxt = 1'b1;
          if (r_os) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_pc_nxt = r_pc + DIV_ONE;
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_div      <= DIV_RST;
      r_pc       <= '0;
      r_os       <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_pc       <= w_pc_nxt;
      r_os       <= w_os_nxt;
      r_tick     <= w_tick_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign tick     = r_tick;
  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign load_err = r_load_err;

`ifdef CLK_PRESCALER_TICK_CNT_EN
  logic [TCNT_W-1:0] r_tick_cnt;

  // clears on an accepted start, holds across stop, wraps silently
  always_ff @(posedge clk) begin
    if (!rst)            r_tick_cnt <= '0;
    else if (w_start_ok) r_tick_cnt <= '0;
    else if (w_tick_nxt) r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
  end

  assign tick_cnt = r_tick_cnt;
`else
  assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_prescaler.sv
// Scenario bench for clk_prescaler: per-cycle expectations queued with the stimulus and compared after each edge.
module tb_clk_prescaler;

  localparam int DIV_W  = 8;
  localparam int TCNT_W = 16;
`ifdef CLK_PRESCALER_TICK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              start    = 1'b0;
  logic              stop     = 1'b0;
  logic              oneshot  = 1'b0;
  logic              div_load = 1'b0;
  logic [DIV_W-1:0]  div_in   = '0;
  logic              tick, busy, done, load_err;
  logic [TCNT_W-1:0] tick_cnt;

  typedef struct packed {
    logic              tick;
    logic              busy;
    logic              done;
    logic              load_err;
    logic [TCNT_W-1:0] cnt;
  } out_t;

  typedef struct {
    logic             rst_n, start, stop, oneshot, div_load;
    logic [DIV_W-1:0] div_in;
    out_t             exp;
  } step_t;

  step_t plan[$];
  out_t  sb[$];
  out_t  got, want;
  int    checks = 0;
  int    errors = 0;

  clk_prescaler #(.DIV_W(DIV_W), .DEFAULT_DIV(4), .TCNT_W(TCNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .div_load(div_load), .div_in(div_in), .tick(tick), .busy(busy),
    .done(done), .load_err(load_err), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input bit r, s, p, o, l, input int di,
                               input bit t, b, d, e, input int n);
    step_t x;
    x.rst_n = r; x.start = s; x.stop = p; x.oneshot = o; x.div_load = l;
    x.div_in = DIV_W'(di);
    x.exp.tick = t; x.exp.busy = b; x.exp.done = d; x.exp.load_err = e;
    x.exp.cnt = CNT_EN ? TCNT_W'(n) : '0;
    return x;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("tick=%b busy=%b done=%b load_err=%b tick_cnt=%0d",
                     o.tick, o.busy, o.done, o.load_err, o.cnt);
  endfunction

  function automatic out_t sample();
    return {tick, busy, done, load_err, tick_cnt};
  endfunction

  task automatic apply_edge(input step_t s);
    rst = s.rst_n; start = s.start; stop = s.stop; oneshot = s.oneshot;
    div_load = s.div_load; div_in = s.div_in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    plan.delete();
    plan.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0));
    plan.push_back(mk(0,1,0,0,1,9, 0,0,0,0,0));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_reset step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_continuous();
    plan.delete();
    plan.push_back(mk(1,1,0,0,0,0, 0,1,0,0,0));
    for (int j = 1; j <= 12; j++) plan.push_back(mk(1,0,0,0,0,0, (j % 4) == 0,1,0,0, j / 4));
    plan.push_back(mk(1,0,1,0,0,0, 0,0,0,0,3));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,3));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_continuous step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_div1();
    plan.delete();
    plan.push_back(mk(1,0,0,0,1,1, 0,0,0,0,3));
    plan.push_back(mk(1,1,0,0,0,0, 0,1,0,0,0));
    for (int j = 1; j <= 5; j++) plan.push_back(mk(1,0,0,0,0,0, 1,1,0,0,j));
    plan.push_back(mk(1,0,1,0,0,0, 0,0,0,0,5));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,5));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_div1 step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_oneshot();
    plan.delete();
    plan.push_back(mk(1,0,0,0,1,3, 0,0,0,0,5));
    plan.push_back(mk(1,1,0,1,0,0, 0,1,0,0,0));
    plan.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0));
    plan.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0));
    plan.push_back(mk(1,0,0,0,0,0, 1,0,1,0,1));
    for (int j = 0; j < 20; j++) plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_oneshot step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_load_err();
    plan.delete();
    plan.push_back(mk(1,0,0,0,1,4, 0,0,0,0,1));
    plan.push_back(mk(1,0,0,0,1,0, 0,0,0,1,1));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1));
    plan.push_back(mk(1,1,0,0,0,0, 0,1,0,0,0));
    plan.push_back(mk(1,0,0,0,1,7, 0,1,0,1,0));
    for (int j = 2; j <= 8; j++) plan.push_back(mk(1,0,0,0,0,0, (j % 4) == 0,1,0,0, j / 4));
    plan.push_back(mk(1,0,1,0,0,0, 0,0,0,0,2));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,2));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_load_err step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stop_terminal();
    plan.delete();
    plan.push_back(mk(1,1,0,0,0,0, 0,1,0,0,0));
    for (int j = 1; j <= 7; j++) plan.push_back(mk(1,0,0,0,0,0, (j % 4) == 0,1,0,0, j / 4));
    plan.push_back(mk(1,0,1,0,0,0, 0,0,0,0,1));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1));
    plan.push_back(mk(1,1,1,0,0,0, 0,0,0,0,1));
    for (int j = 0; j < 4; j++) plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_stop_terminal step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_midrun();
    plan.delete();
    plan.push_back(mk(1,1,0,0,1,5, 0,1,0,0,0));
    for (int j = 1; j <= 7; j++) plan.push_back(mk(1,0,0,0,0,0, (j % 5) == 0,1,0,0, j / 5));
    plan.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0));
    plan.push_back(mk(1,1,0,0,0,0, 0,1,0,0,0));
    for (int j = 1; j <= 8; j++) plan.push_back(mk(1,0,0,0,0,0, (j % 4) == 0,1,0,0, j / 4));
    plan.push_back(mk(1,0,1,0,0,0, 0,0,0,0,2));
    plan.push_back(mk(1,0,0,0,0,0, 0,0,0,0,2));
    foreach (plan[i]) begin
      sb.push_back(plan[i].exp);
      apply_edge(plan[i]);
      want = sb.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_reset_midrun step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_continuous();
    test_div1();
    test_oneshot();
    test_load_err();
    test_stop_terminal();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
